// File: rtl/tlul_err_gate.sv
// TL-UL error gate: forwards legal A requests, answers flagged ones locally.
// Optional error counter enabled with `define TLUL_ERR_GATE_CNT_EN.

package tlul_err_gate_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_AUW = 4;
    localparam int TL_DUW = 4;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

module tlul_err_gate
    import tlul_err_gate_pkg::*;
#(
    parameter int unsigned      MaxOutstanding = 4,
    parameter logic [TL_DW-1:0] ErrRdata       = {TL_DW{1'b1}}
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o,
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    input  logic    err_i
`ifdef TLUL_ERR_GATE_CNT_EN
   ,input  logic        err_cnt_clr_i,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

    typedef enum logic [1:0] {
        ST_PASS,
        ST_DRAIN,
        ST_RESP
    } state_e;

    state_e            r_state;
    logic [CW-1:0]     r_cnt;
    logic [TL_AIW-1:0] r_src;
    logic [TL_SZW-1:0] r_size;
    logic              r_get;

    logic          w_err_req;
    logic          w_room;
    logic          w_inc;
    logic          w_dec;
    logic [CW-1:0] w_cnt_next;

    assign w_err_req = tl_h_i.a_valid & err_i;
    assign w_room    = (r_cnt < MaxCnt);
    assign w_inc     = tl_d_o.a_valid & tl_d_i.a_ready;
    // Only count device responses we actually let through; never wrap below 0.
    assign w_dec     = tl_d_i.d_valid & tl_d_o.d_ready & (r_cnt != '0);

    // Next outstanding count; simultaneous +1/-1 cancel out.
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_inc, w_dec})
            2'b10:   w_cnt_next = r_cnt + 1'b1;
            2'b01:   w_cnt_next = r_cnt - 1'b1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    // Channel steering: pass-through, blocked, or local error response.
    always_comb begin
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = 1'b0;
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = 1'b0;
        case (r_state)
            ST_PASS: begin
                if (w_err_req) begin
                    tl_h_o.a_ready = 1'b1;
                end else begin
                    tl_d_o.a_valid = tl_h_i.a_valid & w_room;
                    tl_h_o.a_ready = tl_d_i.a_ready & w_room;
                end
            end
            ST_RESP: begin
                tl_h_o          = '0;
                tl_h_o.d_valid  = 1'b1;
                tl_h_o.d_error  = 1'b1;
                tl_h_o.d_source = r_src;
                tl_h_o.d_size   = r_size;
                tl_h_o.d_opcode = r_get ? AccessAckData : AccessAck;
                tl_h_o.d_data   = r_get ? ErrRdata : '0;
                tl_d_o.d_ready  = 1'b0;
            end
            default: ;
        endcase
        if (!rst_ni) begin
            tl_h_o.a_ready = 1'b0;
            tl_h_o.d_valid = 1'b0;
            tl_d_o.a_valid = 1'b0;
            tl_d_o.d_ready = 1'b0;
        end
    end

    // Outstanding counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Gate FSM: capture error request, wait for drain, then respond.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_PASS;
            r_src   <= '0;
            r_size  <= '0;
            r_get   <= 1'b0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (w_err_req) begin
                        r_src   <= tl_h_i.a_source;
                        r_size  <= tl_h_i.a_size;
                        r_get   <= (tl_h_i.a_opcode == Get);
                        r_state <= (w_cnt_next == '0) ? ST_RESP : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_cnt_next == '0) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (tl_h_i.d_ready) begin
                        r_state <= ST_PASS;
                    end
                end
                default: r_state <= ST_PASS;
            endcase
        end
    end

`ifdef TLUL_ERR_GATE_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_acc;

    assign w_err_acc = (r_state == ST_PASS) & w_err_req;
    assign err_cnt_o = r_err_cnt;

    // Saturating count of accepted error requests; clear has priority.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (err_cnt_clr_i) begin
            r_err_cnt <= '0;
        end else if (w_err_acc && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tlul_err_gate.sv
// Testbench for tlul_err_gate: vector table, directed corner cases,
// and random traffic against a transaction-level scoreboard.

module tb_tlul_err_gate;
    import tlul_err_gate_pkg::*;

    localparam int MAXO = 4;
    localparam logic [TL_DW-1:0] ERRD = {TL_DW{1'b1}};

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    err = 1'b0;
    tl_h2d_t h_i;
    tl_d2h_t h_o;
    tl_h2d_t d_o;
    tl_d2h_t d_i;
`ifdef TLUL_ERR_GATE_CNT_EN
    logic        clr = 1'b0;
    logic [15:0] ecnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tlul_err_gate #(
        .MaxOutstanding(MAXO),
        .ErrRdata      (ERRD)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .tl_h_i(h_i),
        .tl_h_o(h_o),
        .tl_d_o(d_o),
        .tl_d_i(d_i),
        .err_i (err)
`ifdef TLUL_ERR_GATE_CNT_EN
       ,.err_cnt_clr_i(clr),
        .err_cnt_o    (ecnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        h_i = '0;
        h_i.d_ready = 1'b1;
        d_i = '0;
        d_i.a_ready = 1'b1;
        err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [TL_DW-1:0] dev_data(input logic [7:0] s);
        return 32'hC0DE_0000 | {24'h0, s};
    endfunction

    typedef struct {
        logic av, er, dar, dr;
        logic e_har, e_dav, e_ddr;
    } vec_t;

    typedef struct {
        bit         is_err;
        logic [7:0] src;
        logic [1:0] sz;
        bit         get;
    } exp_t;

    vec_t       tbl[6];
    exp_t       exq[$];
    logic [7:0] devq[$];
    exp_t       ex;
    int         m_cnt;
    bit         busy, pend;
    bit         hs_a, hs_fwd, hs_dd, hs_hd;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        idle();
        step();
        smp();
        chk("rst_a_ready", 64'(h_o.a_ready), 64'd0);
        chk("rst_d_valid", 64'(h_o.d_valid), 64'd0);
        chk("rst_dev_a_valid", 64'(d_o.a_valid), 64'd0);
        chk("rst_dev_d_ready", 64'(d_o.d_ready), 64'd0);
        step();
        rst_n = 1'b1;

        // Single-cycle steering from a fresh PASS state.
        for (int i = 0; i < 6; i++) begin
            idle();
            do_reset();
            h_i.a_valid  = tbl[i].av;
            h_i.a_opcode = Get;
            err          = tbl[i].er;
            d_i.a_ready  = tbl[i].dar;
            h_i.d_ready  = tbl[i].dr;
            smp();
            chk($sformatf("vec%0d_a_ready", i), 64'(h_o.a_ready),
                64'(tbl[i].e_har));
            chk($sformatf("vec%0d_dev_a_valid", i), 64'(d_o.a_valid),
                64'(tbl[i].e_dav));
            chk($sformatf("vec%0d_dev_d_ready", i), 64'(d_o.d_ready),
                64'(tbl[i].e_ddr));
            step();
        end

        // Pass-through Get.
        idle();
        do_reset();
        h_i.a_valid  = 1'b1;
        h_i.a_opcode = Get;
        h_i.a_source = 8'd2;
        smp();
        chk("pt_dev_a_valid", 64'(d_o.a_valid), 64'd1);
        chk("pt_a_ready", 64'(h_o.a_ready), 64'd1);
        step();
        h_i.a_valid = 1'b0;
        step();
        d_i.d_valid  = 1'b1;
        d_i.d_opcode = AccessAckData;
        d_i.d_source = 8'd2;
        d_i.d_data   = 32'h1234;
        smp();
        chk("pt_d_valid", 64'(h_o.d_valid), 64'd1);
        chk("pt_d_data", 64'(h_o.d_data), 64'h1234);
        chk("pt_d_error", 64'(h_o.d_error), 64'd0);
        chk("pt_d_source", 64'(h_o.d_source), 64'd2);
        step();
        d_i.d_valid = 1'b0;

        // Immediate error responses, Get then PutFullData.
        idle();
        do_reset();
        h_i.a_valid  = 1'b1;
        h_i.a_opcode = Get;
        h_i.a_source = 8'd5;
        h_i.a_size   = 2'd2;
        err          = 1'b1;
        smp();
        chk("ie_a_ready", 64'(h_o.a_ready), 64'd1);
        chk("ie_dev_a_valid", 64'(d_o.a_valid), 64'd0);
        step();
        h_i.a_valid = 1'b0;
        err         = 1'b0;
        smp();
        chk("ie_d_valid", 64'(h_o.d_valid), 64'd1);
        chk("ie_d_opcode", 64'(h_o.d_opcode), 64'(AccessAckData));
        chk("ie_d_error", 64'(h_o.d_error), 64'd1);
        chk("ie_d_source", 64'(h_o.d_source), 64'd5);
        chk("ie_d_size", 64'(h_o.d_size), 64'd2);
        chk("ie_d_data", 64'(h_o.d_data), 64'(ERRD));
        step();
        h_i.a_valid  = 1'b1;
        h_i.a_opcode = PutFullData;
        h_i.a_source = 8'd7;
        err          = 1'b1;
        step();
        h_i.a_valid = 1'b0;
        err         = 1'b0;
        smp();
        chk("ie_put_d_valid", 64'(h_o.d_valid), 64'd1);
        chk("ie_put_d_opcode", 64'(h_o.d_opcode), 64'(AccessAck));
        chk("ie_put_d_data", 64'(h_o.d_data), 64'd0);
        chk("ie_put_d_source", 64'(h_o.d_source), 64'd7);
        step();
        smp();
        chk("ie_back_idle", 64'(h_o.d_valid), 64'd0);
        step();

        // Ordering: error waits behind an outstanding device response.
        idle();
        do_reset();
        h_i.a_valid  = 1'b1;
        h_i.a_opcode = PutFullData;
        h_i.a_source = 8'd3;
        step();
        h_i.a_opcode = Get;
        h_i.a_source = 8'd9;
        err          = 1'b1;
        smp();
        chk("ord_err_accept", 64'(h_o.a_ready), 64'd1);
        step();
        h_i.a_valid = 1'b0;
        err         = 1'b0;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("ord_no_early_resp", 64'(h_o.d_valid), 64'd0);
            step();
        end
        d_i.d_valid  = 1'b1;
        d_i.d_opcode = AccessAck;
        d_i.d_source = 8'd3;
        smp();
        chk("ord_dev_first_valid", 64'(h_o.d_valid), 64'd1);
        chk("ord_dev_first_err", 64'(h_o.d_error), 64'd0);
        chk("ord_dev_first_src", 64'(h_o.d_source), 64'd3);
        step();
        d_i.d_valid = 1'b0;
        smp();
        chk("ord_err_next_valid", 64'(h_o.d_valid), 64'd1);
        chk("ord_err_next_err", 64'(h_o.d_error), 64'd1);
        chk("ord_err_next_src", 64'(h_o.d_source), 64'd9);
        step();

        // Backpressure in RESP.
        idle();
        do_reset();
        h_i.d_ready  = 1'b0;
        h_i.a_valid  = 1'b1;
        h_i.a_opcode = Get;
        h_i.a_source = 8'd4;
        h_i.a_size   = 2'd1;
        err          = 1'b1;
        step();
        err          = 1'b0;
        h_i.a_source = 8'd1;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("bp_d_valid", 64'(h_o.d_valid), 64'd1);
            chk("bp_d_source", 64'(h_o.d_source), 64'd4);
            chk("bp_d_size", 64'(h_o.d_size), 64'd1);
            chk("bp_d_data", 64'(h_o.d_data), 64'(ERRD));
            chk("bp_a_ready", 64'(h_o.a_ready), 64'd0);
            chk("bp_dev_a_valid", 64'(d_o.a_valid), 64'd0);
            step();
        end
        h_i.d_ready = 1'b1;
        smp();
        chk("bp_release_valid", 64'(h_o.d_valid), 64'd1);
        step();
        smp();
        chk("bp_pass_a_ready", 64'(h_o.a_ready), 64'd1);
        chk("bp_pass_dev_a_valid", 64'(d_o.a_valid), 64'd1);
        step();
        h_i.a_valid = 1'b0;

        // Outstanding cap.
        idle();
        do_reset();
        h_i.a_valid  = 1'b1;
        h_i.a_opcode = Get;
        for (int i = 0; i < MAXO; i++) begin
            smp();
            chk("cap_fill", 64'(h_o.a_ready), 64'd1);
            step();
        end
        smp();
        chk("cap_blocked", 64'(h_o.a_ready), 64'd0);
        chk("cap_dev_blocked", 64'(d_o.a_valid), 64'd0);
        step();
        d_i.d_valid  = 1'b1;
        d_i.d_opcode = AccessAckData;
        smp();
        chk("cap_same_cycle", 64'(h_o.a_ready), 64'd0);
        chk("cap_d_pass", 64'(h_o.d_valid), 64'd1);
        step();
        d_i.d_valid = 1'b0;
        smp();
        chk("cap_next_cycle", 64'(h_o.a_ready), 64'd1);
        step();
        h_i.a_valid = 1'b0;

        // Reset while in RESP.
        idle();
        do_reset();
        h_i.d_ready  = 1'b0;
        h_i.a_valid  = 1'b1;
        h_i.a_opcode = Get;
        err          = 1'b1;
        step();
        h_i.a_valid = 1'b0;
        err         = 1'b0;
        smp();
        chk("rr_in_resp", 64'(h_o.d_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_force_d_valid", 64'(h_o.d_valid), 64'd0);
        chk("rr_force_a_ready", 64'(h_o.a_ready), 64'd0);
        step();
        rst_n       = 1'b1;
        h_i.d_ready = 1'b1;
        smp();
        chk("rr_after_d_valid", 64'(h_o.d_valid), 64'd0);
        step();
        h_i.a_valid  = 1'b1;
        h_i.a_source = 8'd6;
        smp();
        chk("rr_fwd_valid", 64'(d_o.a_valid), 64'd1);
        chk("rr_fwd_src", 64'(d_o.a_source), 64'd6);
        chk("rr_fwd_ready", 64'(h_o.a_ready), 64'd1);
        step();
        h_i.a_valid = 1'b0;

`ifdef TLUL_ERR_GATE_CNT_EN
        idle();
        do_reset();
        smp();
        chk("ecnt_reset", 64'(ecnt), 64'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            h_i.a_valid = 1'b1;
            err         = 1'b1;
            step();
            h_i.a_valid = 1'b0;
            err         = 1'b0;
            step();
        end
        smp();
        chk("ecnt_three", 64'(ecnt), 64'd3);
        step();
        clr         = 1'b1;
        h_i.a_valid = 1'b1;
        err         = 1'b1;
        step();
        clr         = 1'b0;
        h_i.a_valid = 1'b0;
        err         = 1'b0;
        smp();
        chk("ecnt_clear_wins", 64'(ecnt), 64'd0);
        step();
`endif

        // Random traffic against a transaction-order scoreboard.
        idle();
        do_reset();
        m_cnt = 0;
        busy  = 1'b0;
        exq.delete();
        devq.delete();
        for (int c = 0; c < 3000; c++) begin
            if (!busy && c < 2800 && $urandom_range(9) < 6) begin
                busy          = 1'b1;
                h_i.a_valid   = 1'b1;
                err           = ($urandom_range(3) == 0);
                h_i.a_opcode  = $urandom_range(1) ? Get : PutFullData;
                h_i.a_source  = 8'($urandom);
                h_i.a_size    = 2'($urandom);
                h_i.a_address = $urandom;
            end else if (!busy) begin
                h_i.a_valid = 1'b0;
                err         = 1'($urandom);
            end
            d_i.a_ready = ($urandom_range(4) != 0);
            h_i.d_ready = ($urandom_range(3) != 0);
            if (devq.size() > 0 && (d_i.d_valid || $urandom_range(1) == 1)) begin
                d_i.d_valid  = 1'b1;
                d_i.d_opcode = AccessAckData;
                d_i.d_source = devq[0];
                d_i.d_data   = dev_data(devq[0]);
            end else begin
                d_i.d_valid = 1'b0;
            end
            smp();
            hs_a   = h_i.a_valid & h_o.a_ready;
            hs_fwd = d_o.a_valid & d_i.a_ready;
            hs_dd  = d_i.d_valid & d_o.d_ready;
            hs_hd  = h_o.d_valid & h_i.d_ready;
            pend   = 1'b0;
            foreach (exq[k]) if (exq[k].is_err) pend = 1'b1;
            if (pend && h_i.a_valid)
                chk("rnd_block_pending", 64'(h_o.a_ready), 64'd0);
            if (d_o.a_valid) begin
                chk("rnd_cap", 64'(m_cnt < MAXO), 64'd1);
                chk("rnd_no_fwd_pending", 64'(pend), 64'd0);
            end
            chk("rnd_fwd_match", 64'(hs_fwd), 64'(hs_a & ~err));
            if (hs_hd) begin
                if (exq.size() == 0) begin
                    chk("rnd_spurious_d", 64'd1, 64'd0);
                end else begin
                    ex = exq.pop_front();
                    chk("rnd_d_src", 64'(h_o.d_source), 64'(ex.src));
                    chk("rnd_d_err", 64'(h_o.d_error), 64'(ex.is_err));
                    if (ex.is_err) begin
                        chk("rnd_e_size", 64'(h_o.d_size), 64'(ex.sz));
                        chk("rnd_e_op", 64'(h_o.d_opcode),
                            64'(ex.get ? AccessAckData : AccessAck));
                        chk("rnd_e_data", 64'(h_o.d_data),
                            64'(ex.get ? ERRD : '0));
                    end else begin
                        chk("rnd_dev_data", 64'(h_o.d_data),
                            64'(dev_data(ex.src)));
                    end
                end
            end
            if (hs_fwd) begin
                chk("rnd_fwd_src", 64'(d_o.a_source), 64'(h_i.a_source));
                devq.push_back(h_i.a_source);
                exq.push_back('{1'b0, h_i.a_source, h_i.a_size, 1'b0});
                m_cnt++;
            end
            if (hs_dd) begin
                void'(devq.pop_front());
                m_cnt--;
            end
            if (hs_a && err)
                exq.push_back('{1'b1, h_i.a_source, h_i.a_size,
                                h_i.a_opcode == Get});
            if (hs_a)
                busy = 1'b0;
            step();
        end
        chk("rnd_drained", 64'(exq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
